// File: rtl/servo_recarga.sv
// ---------------------------------------------------------------------------
// servo_recarga
//   Reload-servo controller for the turret. Drives a hobby-servo PWM at all
//   times. A rising edge on the reload request swings the servo to the
//   reload position for PERIODOS_RECARGA PWM periods. The servo then returns
//   to rest for PERIODOS_RETORNO periods, and completion is signalled with a
//   one-cycle fim_recarga pulse.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   recarregar   in   reload request (level; its rising edge starts a sequence)
//   pwm          out  registered servo PWM
//   fim_recarga  out  registered one-cycle "sequence finished" pulse
// ---------------------------------------------------------------------------
module servo_recarga #(
    parameter int PERIODO          = 1_000_000,
    parameter int LARGURA_REPOUSO  = 50_000,
    parameter int LARGURA_RECARGA  = 100_000,
    parameter int PERIODOS_RECARGA = 25,
    parameter int PERIODOS_RETORNO = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic recarregar,
    output logic pwm,
    output logic fim_recarga
);

    localparam int PW   = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int LW   = $clog2(PERIODO + 1);
    localparam int PMAX = (PERIODOS_RECARGA > PERIODOS_RETORNO) ? PERIODOS_RECARGA
                                                                : PERIODOS_RETORNO;
    localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [PW-1:0] PWM_ULT = PW'(PERIODO - 1);
    localparam logic [LW-1:0] W_REP   = LW'(LARGURA_REPOUSO);
    localparam logic [LW-1:0] W_REC   = LW'(LARGURA_RECARGA);
    localparam logic [CW-1:0] REC_ULT = CW'(PERIODOS_RECARGA - 1);
    localparam logic [CW-1:0] RET_ULT = CW'(PERIODOS_RETORNO - 1);

    typedef enum logic [1:0] {
        REPOUSO,
        RECARGA,
        RETORNO,
        FIM
    } estado_t;

    estado_t       estado_q,  estado_d;
    logic [PW-1:0] cnt_pwm_q, cnt_pwm_d;
    logic [CW-1:0] cnt_per_q, cnt_per_d;
    logic [LW-1:0] largura_q, largura_d;
    logic          pwm_q,     pwm_d;
    logic          fim_q,     fim_d;
    logic          rec_ant_q, rec_ant_d;

    logic          fim_periodo;
    logic          borda;
    logic [LW-1:0] largura_sel;

    always_comb begin
        fim_periodo = (cnt_pwm_q == PWM_ULT);
        cnt_pwm_d   = fim_periodo ? '0 : cnt_pwm_q + 1'b1;

        borda       = recarregar & ~rec_ant_q;
        rec_ant_d   = recarregar;

        estado_d    = estado_q;
        cnt_per_d   = cnt_per_q;
        largura_sel = W_REP;

        case (estado_q)
            REPOUSO: begin
                if (borda) begin
                    estado_d  = RECARGA;
                    cnt_per_d = '0;
                end
            end
            RECARGA: begin
                largura_sel = W_REC;
                if (fim_periodo) begin
                    if (cnt_per_q == REC_ULT) begin
                        estado_d  = RETORNO;
                        cnt_per_d = '0;
                    end else begin
                        cnt_per_d = cnt_per_q + 1'b1;
                    end
                end
            end
            RETORNO: begin
                if (fim_periodo) begin
                    if (cnt_per_q == RET_ULT) begin
                        estado_d  = FIM;
                        cnt_per_d = '0;
                    end else begin
                        cnt_per_d = cnt_per_q + 1'b1;
                    end
                end
            end
            FIM: begin
                // A request edge arriving in this cycle is dropped on purpose.
                estado_d = REPOUSO;
            end
            default: estado_d = REPOUSO;
        endcase

        // The width is only updated at the period wrap, so no pulse is ever
        // truncated or stretched mid-period.
        largura_d = fim_periodo ? largura_sel : largura_q;
        pwm_d     = (LW'(cnt_pwm_q) < largura_q);
        fim_d     = (estado_d == FIM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= REPOUSO;
            cnt_pwm_q <= '0;
            cnt_per_q <= '0;
            largura_q <= W_REP;
            pwm_q     <= 1'b0;
            fim_q     <= 1'b0;
            rec_ant_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_pwm_q <= cnt_pwm_d;
            cnt_per_q <= cnt_per_d;
            largura_q <= largura_d;
            pwm_q     <= pwm_d;
            fim_q     <= fim_d;
            rec_ant_q <= rec_ant_d;
        end
    end

    assign pwm         = pwm_q;
    assign fim_recarga = fim_q;

endmodule

// File: tb/tb_servo_recarga.sv
// ---------------------------------------------------------------------------
// tb_servo_recarga
//   Directed bench for servo_recarga with a short PWM period (100 cycles,
//   rest width 5, reload width 10, 3 periods per phase). Outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_servo_recarga;

    logic clock;
    logic reset;
    logic recarregar;
    logic pwm;
    logic fim_recarga;

    int n_cmp = 0;
    int n_err = 0;
    int fim_count = 0;

    servo_recarga #(
        .PERIODO          (100),
        .LARGURA_REPOUSO  (5),
        .LARGURA_RECARGA  (10),
        .PERIODOS_RECARGA (3),
        .PERIODOS_RETORNO (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .recarregar  (recarregar),
        .pwm         (pwm),
        .fim_recarga (fim_recarga)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every sampled high cycle of fim_recarga.
    always @(negedge clock) begin
        if (fim_recarga === 1'b1) fim_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Counts low samples before the next pulse, then the pulse's high samples.
    // Returns after consuming the first low sample that follows the pulse.
    task automatic pulse(output int lo, output int hi);
        lo = 0;
        hi = 0;
        @(negedge clock);
        while (pwm !== 1'b1 && lo < 400) begin
            lo++;
            @(negedge clock);
        end
        while (pwm === 1'b1 && hi < 400) begin
            hi++;
            @(negedge clock);
        end
    endtask

    // One full reload sequence: three reload-width pulses, two rest-width
    // pulses, then fim_recarga 94 samples after the last pulse ends
    // (it coincides with the wrap that starts the next rest pulse).
    task automatic sequencia(input string pfx, input bit second_edge, input bit rec_at_fim);
        int lo, hi, n, base;
        base = fim_count;
        pulse(lo, hi); chk({pfx, "_rec1"}, hi, 10);
        if (second_edge) begin
            recarregar = 1'b0;
            @(negedge clock);
            recarregar = 1'b1;
        end
        pulse(lo, hi); chk({pfx, "_rec2"}, hi, 10);
        pulse(lo, hi); chk({pfx, "_rec3"}, hi, 10);
        pulse(lo, hi); chk({pfx, "_ret1"}, hi, 5);
        pulse(lo, hi); chk({pfx, "_ret2"}, hi, 5);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (fim_recarga !== 1'b1 && n < 300);
        if (rec_at_fim) recarregar = 1'b1;
        chk({pfx, "_fim_delay"}, n, 94);
        pulse(lo, hi); chk({pfx, "_rest1"}, hi, 5);
        pulse(lo, hi); chk({pfx, "_rest2"}, hi, 5);
        chk({pfx, "_fim_pulses"}, fim_count - base, 1);
    endtask

    initial begin
        int lo, hi;
        reset      = 1'b0;
        recarregar = 1'b0;

        // 1. Reset, then the rest-position waveform.
        repeat (5) @(negedge clock);
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_fim", int'(fim_recarga), 0);
        reset = 1'b1;
        pulse(lo, hi); chk("p1_lo", lo, 0);  chk("p1_hi", hi, 5);
        pulse(lo, hi); chk("p2_lo", lo, 94); chk("p2_hi", hi, 5);
        pulse(lo, hi); chk("p3_lo", lo, 94); chk("p3_hi", hi, 5);
        chk("idle_fim", fim_count, 0);

        // 2. Five-cycle request right after a falling edge.
        recarregar = 1'b1;
        repeat (5) @(negedge clock);
        recarregar = 1'b0;
        sequencia("t2", 1'b0, 1'b0);

        // 3. Request held high through the whole sequence and beyond.
        recarregar = 1'b1;
        sequencia("t3", 1'b0, 1'b0);
        chk("t3_total", fim_count, 2);

        // 4. Fresh edge, plus a second edge during reload that must be ignored.
        recarregar = 1'b0;
        @(negedge clock);
        recarregar = 1'b1;
        sequencia("t4", 1'b1, 1'b0);
        chk("t4_total", fim_count, 3);

        // 5. Asynchronous reset in the middle of the reload phase.
        recarregar = 1'b0;
        @(negedge clock);
        recarregar = 1'b1;
        @(negedge clock);
        recarregar = 1'b0;
        pulse(lo, hi); chk("t5_rec1", hi, 10);
        pulse(lo, hi);
        @(negedge clock);
        while (pwm !== 1'b1 && lo < 800) begin
            lo++;
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
        chk("t5_pre_pwm", int'(pwm), 1);
        reset = 1'b0;
        #1;
        chk("t5_async_pwm", int'(pwm), 0);
        repeat (4) @(negedge clock);
        chk("t5_hold_pwm", int'(pwm), 0);
        reset = 1'b1;
        pulse(lo, hi); chk("t5_p1_lo", lo, 0); chk("t5_p1_hi", hi, 5);
        pulse(lo, hi); chk("t5_p2_hi", hi, 5);
        pulse(lo, hi); chk("t5_p3_hi", hi, 5);
        pulse(lo, hi); chk("t5_p4_hi", hi, 5);
        chk("t5_total", fim_count, 3);

        // 6. Request edge landing in the completion cycle is dropped.
        recarregar = 1'b1;
        @(negedge clock);
        recarregar = 1'b0;
        sequencia("t6", 1'b0, 1'b1);
        chk("t6_total", fim_count, 4);
        recarregar = 1'b0;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
